pixel_classifier: RTL and testbench

PIXEL_CLASSIFIER -- requirements
Module: pixel_classifier

---
 rtl/pixel_classifier.sv | 187 ++++++++++++++++++
 tb/tb_pixel_classifier.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_classifier.sv
// pixel_classifier: three-stage wall/tank/bullet pixel classifier.
// Define PIXEL_CLASSIFIER_BULLET_EN to build in the bullet shadows and hit test.
module pixel_classifier #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_COLS  = 20,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [2:0] tank_dir_in,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic       bullet_active,
    output logic [8:0] map_addr,
    input  logic       map_data,
    output logic [9:0] addr,
    output logic [3:0] category,
    output logic [2:0] tank_direct,
    output logic       out_valid
);

    localparam logic [3:0] CAT_NONE   = 4'd0;
    localparam logic [3:0] CAT_WALL   = 4'd1;
    localparam logic [3:0] CAT_TANK   = 4'd2;
    localparam logic [3:0] CAT_BULLET = 4'd3;

    localparam logic [2:0]  DIR_UP = 3'b010;
    localparam logic [10:0] SPR    = 11'(1 << TILE_LOG2);
    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [8:0]  COLS   = 9'(MAP_COLS);

    // Off-screen coordinates behave exactly like a bubble.
    logic vis;
    assign vis = pix_valid
               && ({1'b0, pix_x} < H_LIM)
               && ({1'b0, pix_y} < V_LIM);

    logic [8:0] tile_x;
    logic [8:0] tile_y;
    assign tile_x = 9'(pix_x >> TILE_LOG2);
    assign tile_y = 9'(pix_y >> TILE_LOG2);
    assign map_addr = vis ? (tile_y * COLS + tile_x) : 9'd0;

    // Frame-stable copies of the sprite positions and heading.
    logic [9:0] tank_x_q;
    logic [9:0] tank_y_q;
    logic [2:0] dir_q;

    // Latch tank shadow and heading at vertical blank; 1xx headings are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tank_x_q <= '0;
            tank_y_q <= '0;
            dir_q    <= DIR_UP;
        end else if (frame_start) begin
            tank_x_q <= tank_x;
            tank_y_q <= tank_y;
            if (!tank_dir_in[2]) begin
                dir_q <= tank_dir_in;
            end
        end
    end

    // Offsets are formed at 11 bits so a pixel left/above the sprite
    // lands at or above 1024 and can never pass the box test.
    logic [10:0] tdx;
    logic [10:0] tdy;
    logic        tank_hit_d;
    logic [9:0]  addr_d;
    assign tdx = {1'b0, pix_x} - {1'b0, tank_x_q};
    assign tdy = {1'b0, pix_y} - {1'b0, tank_y_q};
    assign tank_hit_d = vis && (tdx < SPR) && (tdy < SPR);
    assign addr_d = tank_hit_d ? 10'((tdy << TILE_LOG2) + tdx) : 10'd0;

    logic bul_hit_s1;

`ifdef PIXEL_CLASSIFIER_BULLET_EN
    logic [9:0]  bul_x_q;
    logic [9:0]  bul_y_q;
    logic        bul_act_q;
    logic [10:0] bdx;
    logic [10:0] bdy;
    logic        bul_hit_d;
    logic        bul_hit_q;

    // Latch bullet shadow at vertical blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bul_x_q   <= '0;
            bul_y_q   <= '0;
            bul_act_q <= 1'b0;
        end else if (frame_start) begin
            bul_x_q   <= bullet_x;
            bul_y_q   <= bullet_y;
            bul_act_q <= bullet_active;
        end
    end

    assign bdx = {1'b0, pix_x} - {1'b0, bul_x_q};
    assign bdy = {1'b0, pix_y} - {1'b0, bul_y_q};
    assign bul_hit_d = vis && bul_act_q
                     && (bdx < 11'd4) && (bdy < 11'd4);

    // Stage 1 bullet hit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bul_hit_q <= 1'b0;
        end else begin
            bul_hit_q <= bul_hit_d;
        end
    end

    assign bul_hit_s1 = bul_hit_q;
`else
    logic unused_bullet;
    assign unused_bullet = ^{bullet_x, bullet_y, bullet_active};
    assign bul_hit_s1 = 1'b0;
`endif

    // Stage 1: hit flags, sprite ROM address and validity.
    logic       v1_q;
    logic       tank_hit_q;
    logic [9:0] addr_q;

    // Register stage 1 results for the pixel of the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            tank_hit_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            v1_q       <= vis;
            tank_hit_q <= tank_hit_d;
            addr_q     <= addr_d;
        end
    end

    // Resolve category by priority; map_data belongs to the stage 1 pixel.
    logic [3:0] cat2_d;
    always_comb begin
        cat2_d = CAT_NONE;
        if (!v1_q) begin
            cat2_d = CAT_NONE;
        end else if (bul_hit_s1) begin
            cat2_d = CAT_BULLET;
        end else if (tank_hit_q) begin
            cat2_d = CAT_TANK;
        end else if (map_data) begin
            cat2_d = CAT_WALL;
        end
    end

    logic       v2_q;
    logic [3:0] cat2_q;
    logic       v3_q;
    logic [3:0] cat3_q;

    // Stages 2 and 3: resolved category, then one more delay to line up
    // with the downstream ROM plus colour register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            cat2_q <= CAT_NONE;
            v3_q   <= 1'b0;
            cat3_q <= CAT_NONE;
        end else begin
            v2_q   <= v1_q;
            cat2_q <= cat2_d;
            v3_q   <= v2_q;
            cat3_q <= cat2_q;
        end
    end

    assign addr        = addr_q;
    assign category    = cat3_q;
    assign out_valid   = v3_q;
    assign tank_direct = dir_q;

endmodule

// File: tb/tb_pixel_classifier.sv
// tb_pixel_classifier: directed stimulus with a per-pixel behavioural model.
// Honours PIXEL_CLASSIFIER_BULLET_EN the same way as the design.
module tb_pixel_classifier;

    localparam int H = 640;
    localparam int V = 480;
    localparam int N = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [9:0] tank_x = '0;
    logic [9:0] tank_y = '0;
    logic [2:0] tank_dir_in = '0;
    logic [9:0] bullet_x = '0;
    logic [9:0] bullet_y = '0;
    logic       bullet_active = 1'b0;
    logic [8:0] map_addr;
    logic       map_data = 1'b0;
    logic [9:0] addr;
    logic [3:0] category;
    logic [2:0] tank_direct;
    logic       out_valid;

    pixel_classifier dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir_in(tank_dir_in),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .map_addr(map_addr),
        .map_data(map_data), .addr(addr), .category(category),
        .tank_direct(tank_direct), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit wall [0:511];
    int exp_map [0:N-1];
    int exp_addr [0:N-1];
    int exp_val [0:N-1];
    int exp_cat [0:N-1];
    int exp_dir [0:N-1];

    int m_tx = 0;
    int m_ty = 0;
    int m_bx = 0;
    int m_by = 0;
    bit m_ba = 1'b0;
    int m_dir = 2;

    // Wall RAM with one cycle of read latency.
    always @(posedge clk) map_data <= wall[map_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare every output on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("map_addr", int'(map_addr), exp_map[cyc]);
            chk("addr", int'(addr), exp_addr[cyc]);
            chk("out_valid", int'(out_valid), exp_val[cyc]);
            chk("category", int'(category), exp_cat[cyc]);
            chk("tank_direct", int'(tank_direct), exp_dir[cyc]);
        end
    end

    // Drive one cycle and record what the outputs must become.
    task automatic drive(input bit v, input int x, input int y,
                         input bit fs, output int k);
        bit ev;
        bit th;
        bit bh;
        bit wl;
        int dx;
        int dy;
        int idx;
        @(posedge clk);
        #1;
        k = cyc;
        pix_valid = v;
        pix_x = 10'(x);
        pix_y = 10'(y);
        frame_start = fs;
        ev = v && (x < H) && (y < V);
        idx = ev ? (y / 32) * 20 + (x / 32) : 0;
        exp_map[k] = idx;
        exp_dir[k] = m_dir;
        dx = x - m_tx;
        dy = y - m_ty;
        th = ev && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        bh = 1'b0;
`ifdef PIXEL_CLASSIFIER_BULLET_EN
        bh = ev && m_ba && (x - m_bx) >= 0 && (x - m_bx) < 4
             && (y - m_by) >= 0 && (y - m_by) < 4;
`endif
        wl = ev && wall[idx];
        exp_addr[k+1] = th ? dy * 32 + dx : 0;
        exp_val[k+3] = ev ? 1 : 0;
        exp_cat[k+3] = bh ? 3 : th ? 2 : wl ? 1 : 0;
        if (fs) begin
            m_tx = int'(tank_x);
            m_ty = int'(tank_y);
            m_bx = int'(bullet_x);
            m_by = int'(bullet_y);
            m_ba = bullet_active;
            if (!tank_dir_in[2]) m_dir = int'(tank_dir_in);
        end
        exp_dir[k+1] = m_dir;
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, k);
    endtask

    // Assert reset mid-cycle and check the outputs before any edge.
    task automatic hit_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", int'(addr), 0);
        chk("rst_category", int'(category), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_tank_direct", int'(tank_direct), 2);
        for (int i = 1; i <= 4; i++) begin
            exp_addr[cyc+i] = 0;
            exp_val[cyc+i] = 0;
            exp_cat[cyc+i] = 0;
        end
        m_tx = 0;
        m_ty = 0;
        m_bx = 0;
        m_by = 0;
        m_ba = 1'b0;
        m_dir = 2;
    endtask

    initial begin
        int k;
        wall[43] = 1'b1;
        #1 hit_reset();
        idle(2);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Tank, wall and bullet priority.
        tank_x = 100; tank_y = 64; tank_dir_in = 3'b001;
        bullet_x = 100; bullet_y = 64; bullet_active = 1'b1;
        drive(1'b0, 0, 0, 1'b1, k);
        chk("pin_dir_001", m_dir, 1);
        drive(1'b1, 105, 70, 1'b0, k);
        chk("pin_addr_197", exp_addr[k+1], 197);
        chk("pin_cat_tank", exp_cat[k+3], 2);
        chk("pin_val_tank", exp_val[k+3], 1);
        drive(1'b1, 100, 64, 1'b0, k);
        chk("pin_map_43", exp_map[k], 43);
`ifdef PIXEL_CLASSIFIER_BULLET_EN
        chk("pin_cat_bullet", exp_cat[k+3], 3);
`else
        chk("pin_cat_bullet_off", exp_cat[k+3], 2);
`endif
        drive(1'b1, 96, 70, 1'b0, k);
        chk("pin_cat_wall", exp_cat[k+3], 1);
        drive(1'b1, 10, 10, 1'b0, k);
        chk("pin_cat_none", exp_cat[k+3], 0);
        chk("pin_val_none", exp_val[k+3], 1);
        drive(1'b0, 105, 70, 1'b0, k);
        chk("pin_bubble", exp_val[k+3], 0);

        // Mid-frame moves are shadowed; 1xx heading is ignored.
        tank_x = 300;
        drive(1'b1, 105, 70, 1'b0, k);
        chk("pin_shadow_old", exp_cat[k+3], 2);
        drive(1'b1, 305, 70, 1'b0, k);
        chk("pin_shadow_new_miss", exp_cat[k+3], 0);
        tank_dir_in = 3'b111;
        drive(1'b1, 105, 70, 1'b1, k);
        chk("pin_fs_same_cycle", exp_cat[k+3], 2);
        chk("pin_dir_hold", m_dir, 1);
        drive(1'b1, 305, 70, 1'b0, k);
        chk("pin_shadow_new_addr", exp_addr[k+1], 197);
        drive(1'b1, 105, 70, 1'b0, k);
        chk("pin_shadow_wall", exp_cat[k+3], 1);
        idle(3);

        // Full row streamed back to back with one bubble; right-edge clip.
        tank_x = 620; tank_y = 64; tank_dir_in = 3'b011;
        bullet_active = 1'b0;
        drive(1'b0, 0, 0, 1'b1, k);
        for (int x = 0; x < H; x++) begin
            drive(x != 300, x, 64, 1'b0, k);
            if (x == 639) begin
                chk("pin_edge_addr_19", exp_addr[k+1], 19);
                chk("pin_edge_cat", exp_cat[k+3], 2);
            end
        end
        drive(1'b1, 640, 64, 1'b0, k);
        chk("pin_offscreen_x", exp_val[k+3], 0);
        chk("pin_offscreen_map", exp_map[k], 0);
        drive(1'b1, 10, 480, 1'b0, k);
        chk("pin_offscreen_y", exp_val[k+3], 0);

        // Reset with pixels in flight.
        drive(1'b1, 625, 70, 1'b0, k);
        drive(1'b1, 100, 64, 1'b0, k);
        hit_reset();
        idle(3);
        rst_n = 1'b1;
        drive(1'b1, 5, 5, 1'b0, k);
        chk("pin_post_rst_addr", exp_addr[k+1], 165);
        chk("pin_post_rst_cat", exp_cat[k+3], 2);
        chk("pin_post_rst_dir", m_dir, 2);
        drive(1'b1, 625, 70, 1'b0, k);
        idle(6);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
